// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage M-extension unit: funct3 encodings,
// controller states, datapath widths and a small two's-complement helper.
package ex_muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // RV32M funct3 encodings as they arrive on op_E.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  // Two's-complement negate when neg is set; used for magnitudes and
  // for the sign fix-up of divider results.
  function automatic logic [XLEN-1:0] neg_if(input logic neg,
                                              input logic [XLEN-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes. One quotient bit per
// cycle for DIV_ITERS cycles. quotient/remainder present the values that
// the current iteration produces, so they are final while finished=1.
module muldiv_div_iter
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            finished
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             run_q, run_d;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_quo;

  // One restoring step: shift in the next dividend bit, try to subtract.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  assign quotient  = step_quo;
  assign remainder = step_rem;
  assign finished  = run_q & (cnt_q == '0);

  // Load on start, iterate while running, stop after the last step or abort.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    run_d = run_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(DIV_ITERS - 1);
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (run_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) run_d = 1'b0;
    end
  end

  // Divider state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit. The multiply and the divide special cases are
// resolved on the cycle the instruction arrives and presented the next
// cycle; ordinary divides run through the iterative divider. busy stalls
// the front of the pipeline until the result cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] srcA_E,
  input  logic [XLEN-1:0] srcB_E,
  input  logic            flush_E,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  // Multiplier operands: live inputs when accepting, latched copies after.
  logic [2:0]          mul_op;
  logic [XLEN-1:0]     mul_a, mul_b;
  logic signed [XLEN:0]     mul_a_ext, mul_b_ext;
  logic signed [2*XLEN+1:0] product;
  logic [XLEN-1:0]     mul_res;

  // Divide special-case detection and operand magnitudes (live inputs).
  logic            div_signed_in;
  logic            div_by_zero;
  logic            div_overflow;
  logic            div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] dvd_mag, dvs_mag;

  // Divider handshake and sign fix-up of its magnitudes.
  logic            div_start;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            div_fin;
  logic            div_signed_q;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res;

  logic            accept;

  assign accept = start_E & ~flush_E;
  assign busy   = start_E & (state_q != S_DONE) & ~flush_E;
  assign done   = done_q;
  assign result = result_q;

  // 33x33 signed multiply; the extension bit chooses operand signedness.
  always_comb begin
    mul_op    = (state_q == S_IDLE) ? op_E   : op_q;
    mul_a     = (state_q == S_IDLE) ? srcA_E : a_q;
    mul_b     = (state_q == S_IDLE) ? srcB_E : b_q;
    mul_a_ext = {((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) & mul_a[XLEN-1], mul_a};
    mul_b_ext = {(mul_op == OP_MULH) & mul_b[XLEN-1], mul_b};
    product   = mul_a_ext * mul_b_ext;
    mul_res   = (mul_op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // Divide-by-zero and signed overflow bypass the iterative divider.
  always_comb begin
    div_signed_in = ~op_E[0];
    div_by_zero   = (srcB_E == '0);
    div_overflow  = div_signed_in & (srcA_E == {1'b1, {(XLEN-1){1'b0}}}) & (srcB_E == '1);
    div_special   = div_by_zero | div_overflow;
    if (div_by_zero) begin
      special_res = op_E[1] ? srcA_E : '1;
    end else begin
      special_res = op_E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
    dvd_mag = neg_if(div_signed_in & srcA_E[XLEN-1], srcA_E);
    dvs_mag = neg_if(div_signed_in & srcB_E[XLEN-1], srcB_E);
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  always_comb begin
    div_signed_q = ~op_q[0];
    quo_fix      = neg_if(div_signed_q & (a_q[XLEN-1] ^ b_q[XLEN-1]), div_quo);
    rem_fix      = neg_if(div_signed_q & a_q[XLEN-1], div_rem);
    div_res      = op_q[1] ? rem_fix : quo_fix;
  end

  muldiv_div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush_E),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .finished  (div_fin)
  );

  // Controller next state; flush overrides everything and discards the op.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op_E;
          a_d  = srcA_E;
          b_d  = srcB_E;
          if (!op_E[2]) begin
            // The multiply finishes within the accepting cycle.
            result_d = mul_res;
            state_d  = S_DONE;
          end else if (div_special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            div_start = 1'b1;
            state_d   = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (div_fin) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush_E) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
    done_d = (state_d == S_DONE);
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule
